// File: rtl/mem_backing_responder.sv
// mem_backing_responder
// ---------------------------------------------------------------------------
// Memory-side responder for the cache's 128-bit memory request interface.
// It models DRAM behind the cache in simulation and FPGA builds. One request
// is serviced at a time, and every request moves one full cache line as a
// 4-beat burst.
//   - Writes: after the request is accepted, four byte-masked data beats are
//     taken, one on each cycle where mem_req_data_valid is high.
//   - Reads: after LATENCY idle cycles, four response beats are returned on
//     consecutive cycles. The requester cannot apply back-pressure.
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               asynchronous, active-low; clears control state only
//   mem_req_valid       request present
//   mem_req_ready       responder can accept a request (registered)
//   mem_req_addr        128-bit word address of the line; bits [1:0] ignored
//   mem_req_rw          1 = write, 0 = read
//   mem_req_data_valid  write beat present
//   mem_req_data_ready  responder accepts a write beat (registered)
//   mem_req_data_bits   write beat data
//   mem_req_data_mask   byte enables for the write beat
//   mem_resp_valid      read beat valid (registered)
//   mem_resp_data       read beat data (registered)
// ---------------------------------------------------------------------------
module mem_backing_responder #(
  parameter int MEM_DATA_BITS = 128,
  parameter int ADDR_BITS     = 28,
  parameter int DEPTH_LOG2    = 12,
  parameter int LATENCY       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic [ADDR_BITS-1:0]       mem_req_addr,
  input  logic                       mem_req_rw,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int MASK_BITS = MEM_DATA_BITS / 8;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    RLAT   = 2'd2,
    RBURST = 2'd3
  } state_t;

  state_t                   state_r;
  logic [DEPTH_LOG2-1:0]    base_r;
  logic [1:0]               beat_r;
  logic [3:0]               lat_r;
  logic [MEM_DATA_BITS-1:0] mem_r [DEPTH];

  logic [DEPTH_LOG2-1:0]    word_idx_s;
  logic                     wr_en_s;
  logic                     addr_unused_s;

  // Byte-lane merge: lanes whose mask bit is set take the new data, and the
  // other lanes keep the old word.
  function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
    input logic [MEM_DATA_BITS-1:0] old_word,
    input logic [MEM_DATA_BITS-1:0] new_word,
    input logic [MASK_BITS-1:0]     mask
  );
    logic [MEM_DATA_BITS-1:0] res;
    res = old_word;
    for (int i = 0; i < MASK_BITS; i++) begin
      res[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  // Address bits above the storage size alias onto lower words, and bits
  // [1:0] never offset a burst, so those bits are intentionally dropped.
  assign addr_unused_s = ^{mem_req_addr[ADDR_BITS-1:DEPTH_LOG2], mem_req_addr[1:0]};

  // Current beat's word index; it wraps modulo the storage depth by width.
  always_comb begin
    word_idx_s = base_r + {{(DEPTH_LOG2-2){1'b0}}, beat_r};
    wr_en_s    = mem_req_data_ready & mem_req_data_valid;
  end

  // Line storage: byte-masked write of the current beat. It has no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[word_idx_s] <= merge_bytes(mem_r[word_idx_s], mem_req_data_bits, mem_req_data_mask);
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r            <= IDLE;
      base_r             <= {DEPTH_LOG2{1'b0}};
      beat_r             <= 2'd0;
      lat_r              <= 4'd0;
      mem_req_ready      <= 1'b1;
      mem_req_data_ready <= 1'b0;
      mem_resp_valid     <= 1'b0;
      mem_resp_data      <= {MEM_DATA_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_req_valid && mem_req_ready) begin
            base_r        <= {mem_req_addr[DEPTH_LOG2-1:2], 2'b00};
            mem_req_ready <= 1'b0;
            if (mem_req_rw) begin
              state_r            <= WDATA;
              mem_req_data_ready <= 1'b1;
            end else begin
              state_r <= RLAT;
              lat_r   <= LAT_INIT;
            end
          end
        end

        WDATA: begin
          if (mem_req_data_valid) begin
            beat_r <= beat_r + 2'd1;  // wraps to 0 after beat 3
            if (beat_r == 2'd3) begin
              state_r            <= IDLE;
              mem_req_data_ready <= 1'b0;
              mem_req_ready      <= 1'b1;
            end
          end
        end

        RLAT: begin
          if (lat_r == 4'd0) begin
            // beat_r is 0 here, so this loads the first word of the line.
            state_r        <= RBURST;
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= mem_r[word_idx_s];
            beat_r         <= beat_r + 2'd1;
          end else begin
            lat_r <= lat_r - 4'd1;
          end
        end

        RBURST: begin
          // Beat 0 was loaded on entry. The counter wraps back to 0 once
          // beat 3 has been loaded, which marks the end of the burst.
          if (beat_r == 2'd0) begin
            state_r        <= IDLE;
            mem_resp_valid <= 1'b0;
            mem_req_ready  <= 1'b1;
          end else begin
            mem_resp_data <= mem_r[word_idx_s];
            beat_r        <= beat_r + 2'd1;
          end
        end

        default: begin
          state_r            <= IDLE;
          beat_r             <= 2'd0;
          lat_r              <= 4'd0;
          mem_req_ready      <= 1'b1;
          mem_req_data_ready <= 1'b0;
          mem_resp_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule
